// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the divide-sequencer state encoding, the register address width
// and a small helper used by the load-use comparator.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_BITS = 5;

  typedef enum logic [1:0] {
    HZ_IDLE     = 2'd0,
    HZ_DIV_RUN  = 2'd1,
    HZ_DIV_DONE = 2'd2
  } hz_state_e;

  // True when an ID source operand is read and names the given EXE destination.
  function automatic logic src_hits(input logic uses,
                                    input logic [REG_ADDR_BITS-1:0] rs,
                                    input logic [REG_ADDR_BITS-1:0] rd);
    return uses & (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_hz_div_seq.sv
// hz_div_seq: multi-cycle divide sequencer.
// A divide seen in EXE while idle fires a one-cycle div_start, then the
// pipeline is held for DIV_CYCLES further cycles while the down-counter
// runs out, followed by exactly one div_done cycle in which all holds drop.
// div_busy covers the entry cycle and every RUN cycle.
// All outputs are forced low while nrst is low so the pipeline sees a clean
// idle controller during reset, even before the synchronous reset edge.
module hz_div_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 34
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       exe_is_div,
  output logic       div_start,
  output logic       div_done,
  output logic       div_busy,
  output logic [1:0] state_o
);

  localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

  hz_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_c, done_c, busy_c;

  // State register and down-counter; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update and raw sequencer outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_c = 1'b0;
    done_c  = 1'b0;
    busy_c  = 1'b0;
    case (state_q)
      HZ_IDLE: begin
        if (exe_is_div) begin
          start_c = 1'b1;
          busy_c  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = HZ_DIV_RUN;
        end
      end
      HZ_DIV_RUN: begin
        busy_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = HZ_DIV_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HZ_DIV_DONE: begin
        // The divide leaves EXE this cycle; a divide now in EXE is the
        // previous one and must not restart the sequence.
        done_c  = 1'b1;
        state_d = HZ_IDLE;
      end
      default: begin
        state_d = HZ_IDLE;
      end
    endcase
  end

  assign div_start = nrst & start_c;
  assign div_done  = nrst & done_c;
  assign div_busy  = nrst & busy_c;
  assign state_o   = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush generator for the 5-stage RV32IMC pipeline.
// Resolves, in priority order: multi-cycle divide in EXE (hz_div_seq),
// load-use between EXE load and ID consumer (one bubble), and taken
// branch/jump resolved in ID (flush IF/ID). All controls are combinational
// from inputs and registered sequencer state.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush
// performance counters; without it both counter ports are tied to 0.
// dbg_state exposes the divide sequencer state for observation.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 34,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [REG_ADDR_BITS-1:0] id_rs1,
  input  logic [REG_ADDR_BITS-1:0] id_rs2,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic                     id_branch_taken,
  input  logic [REG_ADDR_BITS-1:0] exe_rd,
  input  logic                     exe_is_load,
  input  logic                     exe_is_div,
  output logic                     pc_stall,
  output logic                     if_id_stall,
  output logic                     if_id_flush,
  output logic                     id_exe_stall,
  output logic                     id_exe_flush,
  output logic                     exe_mem_flush,
  output logic                     div_start,
  output logic                     div_done,
  output logic [CNT_WIDTH-1:0]     stall_cnt,
  output logic [CNT_WIDTH-1:0]     flush_cnt,
  output logic [1:0]               dbg_state
);

  logic div_busy;
  logic load_use;
  logic src_hit;

  hz_div_seq #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_seq (
    .clk       (clk),
    .nrst      (nrst),
    .exe_is_div(exe_is_div),
    .div_start (div_start),
    .div_done  (div_done),
    .div_busy  (div_busy),
    .state_o   (dbg_state)
  );

  // Load-use detection; only meaningful when idle and no divide is entering.
  always_comb begin
    src_hit  = src_hits(id_uses_rs1, id_rs1, exe_rd) |
               src_hits(id_uses_rs2, id_rs2, exe_rd);
    load_use = nrst & (dbg_state == HZ_IDLE) & ~div_busy &
               exe_is_load & (exe_rd != '0) & src_hit;
  end

  // Stall/flush fan-out. A divide freezes everything up to EXE and feeds
  // bubbles into MEM; a load-use holds PC and IF/ID and bubbles EXE. A taken
  // branch only flushes IF/ID when nothing is stalling, since ID operands
  // are not final while held.
  always_comb begin
    pc_stall      = div_busy | load_use;
    if_id_stall   = div_busy | load_use;
    id_exe_stall  = div_busy;
    id_exe_flush  = load_use;
    exe_mem_flush = div_busy;
    if_id_flush   = nrst & id_branch_taken & ~div_busy & ~load_use;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if (if_id_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl with DIV_CYCLES=4, CNT_WIDTH=3.
// Output vector order: {pc_stall, if_id_stall, if_id_flush, id_exe_stall,
//                       id_exe_flush, exe_mem_flush, div_start, div_done}.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int TB_DIV = 4;
  localparam int TB_CW  = 3;

  // Expected output patterns.
  localparam logic [7:0] O_IDLE  = 8'b0000_0000;
  localparam logic [7:0] O_LU    = 8'b1100_1000;
  localparam logic [7:0] O_BR    = 8'b0010_0000;
  localparam logic [7:0] O_DSTRT = 8'b1101_0110;
  localparam logic [7:0] O_DRUN  = 8'b1101_0100;
  localparam logic [7:0] O_DDONE = 8'b0000_0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic [4:0] id_rs1, id_rs2, exe_rd;
  logic id_uses_rs1, id_uses_rs2, id_branch_taken, exe_is_load, exe_is_div;
  logic pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush;
  logic exe_mem_flush, div_start, div_done;
  logic [TB_CW-1:0] stall_cnt, flush_cnt;
  logic [1:0] dbg_state;

  hazard_ctrl #(.DIV_CYCLES(TB_DIV), .CNT_WIDTH(TB_CW)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_branch_taken(id_branch_taken),
    .exe_rd         (exe_rd),
    .exe_is_load    (exe_is_load),
    .exe_is_div     (exe_is_div),
    .pc_stall       (pc_stall),
    .if_id_stall    (if_id_stall),
    .if_id_flush    (if_id_flush),
    .id_exe_stall   (id_exe_stall),
    .id_exe_flush   (id_exe_flush),
    .exe_mem_flush  (exe_mem_flush),
    .div_start      (div_start),
    .div_done       (div_done),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [TB_CW-1:0] exp_stall_cnt = '0;
  logic [TB_CW-1:0] exp_flush_cnt = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    id_rs1 = '0; id_rs2 = '0; exe_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_branch_taken = 1'b0;
    exe_is_load = 1'b0; exe_is_div = 1'b0;
  endtask

  // One cycle: expectation queued with the stimulus, compared mid-cycle.
  task automatic step(input string name, input logic [7:0] exp, input logic [1:0] exp_st);
    logic [7:0] e;
    logic [7:0] got;
    exp_q.push_back(exp);
    @(negedge clk);
    got = {pc_stall, if_id_stall, if_id_flush, id_exe_stall,
           id_exe_flush, exe_mem_flush, div_start, div_done};
    e = exp_q.pop_front();
    check({name, ".out"}, 32'(got), 32'(e));
    check({name, ".state"}, 32'(dbg_state), 32'(exp_st));
    check({name, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall_cnt));
    check({name, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_flush_cnt));
`ifdef HAZARD_PERF_CNT_EN
    if (!nrst) begin
      exp_stall_cnt = '0;
      exp_flush_cnt = '0;
    end else begin
      if (e[7] && exp_stall_cnt != '1) exp_stall_cnt = exp_stall_cnt + 1'b1;
      if (e[5] && exp_flush_cnt != '1) exp_flush_cnt = exp_flush_cnt + 1'b1;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       load;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[1] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, O_LU};
    vecs[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, O_IDLE};
    vecs[3] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[4] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, O_LU};
    vecs[5] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, O_IDLE};
    vecs[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, O_BR};
    vecs[7] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, O_LU};
    vecs[8] = '{1'b1, 5'd6, 5'd5, 5'd4, 1'b1, 1'b1, 1'b1, O_BR};

    // reset
    nrst = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    step("reset", O_IDLE, HZ_IDLE);
    nrst = 1'b1;

    // table-driven single-cycle hazards while idle
    for (int i = 0; i < 9; i++) begin
      exe_is_load = vecs[i].load; exe_rd = vecs[i].rd;
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
      id_branch_taken = vecs[i].br;
      step($sformatf("vec%0d", i), vecs[i].exp, HZ_IDLE);
    end
    drive_idle();
    step("after_lu", O_IDLE, HZ_IDLE);

    // divide with a taken branch held in ID: branch must not flush while stalled
    exe_is_div = 1'b1; id_branch_taken = 1'b1;
    step("div_start", O_DSTRT, HZ_IDLE);
    for (int i = 1; i <= TB_DIV; i++) step($sformatf("div_run%0d", i), O_DRUN, HZ_DIV_RUN);
    id_branch_taken = 1'b0;
    step("div_done", O_DDONE, HZ_DIV_DONE);
    // back-to-back: second divide starts the cycle after div_done
    step("div2_start", O_DSTRT, HZ_IDLE);
    for (int i = 1; i <= TB_DIV; i++) step($sformatf("div2_run%0d", i), O_DRUN, HZ_DIV_RUN);
    step("div2_done", O_DDONE, HZ_DIV_DONE);
    exe_is_div = 1'b0;
    step("div2_idle", O_IDLE, HZ_IDLE);

    // reset in the second RUN cycle
    exe_is_div = 1'b1;
    step("rdiv_start", O_DSTRT, HZ_IDLE);
    step("rdiv_run1", O_DRUN, HZ_DIV_RUN);
    nrst = 1'b0;
    step("rdiv_in_reset", O_IDLE, HZ_DIV_RUN);
    nrst = 1'b1; exe_is_div = 1'b0;
    for (int i = 0; i < 4; i++) step($sformatf("rdiv_after%0d", i), O_IDLE, HZ_IDLE);

    // ten load-use stall cycles: counter saturates at 7
    exe_is_load = 1'b1; exe_rd = 5'd12; id_rs2 = 5'd12; id_uses_rs2 = 1'b1;
    for (int i = 0; i < 10; i++) step($sformatf("sat%0d", i), O_LU, HZ_IDLE);
    drive_idle();
    step("sat_idle", O_IDLE, HZ_IDLE);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_saturated", 32'(stall_cnt), 32'd7);
`else
    check("stall_cnt_absent", 32'(stall_cnt), 32'd0);
`endif

    // randomized idle branch/no-hazard cycles
    for (int i = 0; i < 8; i++) begin
      id_branch_taken = 1'($urandom_range(0, 1));
      exe_rd = 5'($urandom_range(1, 31));
      id_rs1 = exe_rd + 5'd1;
      id_uses_rs1 = 1'b1;
      exe_is_load = 1'b1;
      step($sformatf("rnd%0d", i), id_branch_taken ? O_BR : O_IDLE, HZ_IDLE);
    end
    drive_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32IMC core. Generates stall and flush controls for the PC, IF/ID, ID/EXE and EXE/MEM pipeline registers. It resolves load-use hazards, taken branches/jumps resolved in ID, and multi-cycle divide sequencing in EXE. It sits in core.v beside the forwarding unit and drives the enable/flush pins of every pipeline register.

## Interface
- DIV_CYCLES, 34: divider busy cycles after start (≥2).
- CNT_WIDTH, 32: width of performance counters.
- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- id_rs1, id_rs2  in  5  source register addresses of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1/rs2.
- id_branch_taken  in  1  branch/jump in ID resolved taken.
- exe_rd  in  5  destination register of the instruction in EXE.
- exe_is_load  in  1  EXE instruction is a load.
- exe_is_div  in  1  EXE instruction is DIV/DIVU/REM/REMU.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID contents.
- if_id_flush  out  1  zero IF/ID on next edge.
- id_exe_stall  out  1  hold ID/EXE contents.
- id_exe_flush  out  1  zero ID/EXE on next edge (bubble).
- exe_mem_flush  out  1  zero EXE/MEM on next edge.
- div_start  out  1  one-cycle start pulse to divider.
- div_done  out  1  divider result valid this cycle.
- stall_cnt, flush_cnt  out  CNT_WIDTH  performance counters.

## Operation
- FSM states: HZ_IDLE, HZ_DIV_RUN, HZ_DIV_DONE. Reset → HZ_IDLE, counter 0.
- HZ_IDLE with exe_is_div=1: div_start=1. Assert pc_stall, if_id_stall, id_exe_stall and exe_mem_flush. Load counter with DIV_CYCLES-1. Next state HZ_DIV_RUN.
- HZ_DIV_RUN: the same four stall/flush outputs stay asserted and the counter decrements. At counter==0, next state is HZ_DIV_DONE.
- HZ_DIV_DONE: div_done=1 and all stalls are released, so the divide moves to MEM. exe_is_div is ignored. Next state HZ_IDLE.
- Load-use, evaluated only in HZ_IDLE with no divide entry: exe_is_load & exe_rd≠0 & ((id_uses_rs1 & id_rs1==exe_rd) | (id_uses_rs2 & id_rs2==exe_rd)). This asserts pc_stall, if_id_stall and id_exe_flush.
- Branch flush: if_id_flush = id_branch_taken & ~any stall. It is suppressed during a load-use stall or a divide stall, because ID operands or state are not final.
- Priority: divide > load-use > branch flush.
- All outputs are 0 while nrst=0 and in HZ_IDLE with no hazard.

## Timing
- Stall/flush outputs are combinational from inputs and state. State and counter are registered.
- Divide: stall asserted for DIV_CYCLES+1 consecutive cycles (entry cycle plus DIV_CYCLES in RUN), then exactly 1 HZ_DIV_DONE cycle.
- Back-to-back divides: the next divide is seen in HZ_IDLE the cycle after HZ_DIV_DONE.
- Load-use: exactly 1 stall cycle; the bubble appears in EXE one cycle later.
- Reset mid-divide: state goes to HZ_IDLE and the counter clears on the same edge. No div_done is produced.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on every cycle with pc_stall=1.
  - flush_cnt increments on every cycle with if_id_flush=1.
  - Both counters saturate at all-ones and clear on reset.
- HAZARD_PERF_CNT_EN undefined: both ports are driven constant 0 and no counter flops exist.

## Structure
- constants.vh gets:
  - `HZ_IDLE/`HZ_DIV_RUN/`HZ_DIV_DONE (2-bit state encodings).
  - `REG_ADDR_BITS (5).
- One sub-module, hz_div_seq, holds the divide FSM and down-counter. It outputs div_start, div_done and div_busy.
- hazard_ctrl itself holds the load-use/branch logic and the counters.

## Test plan
- exe_is_load=1, exe_rd=5, id_rs1=5, id_uses_rs1=1 -> pc_stall=if_id_stall=id_exe_flush=1 for 1 cycle; exe_rd=0 gives no stall.
- id_branch_taken=1, no hazards -> if_id_flush=1 that cycle. With a simultaneous load-use hit -> if_id_flush=0.
- exe_is_div=1, DIV_CYCLES=4 -> div_start on cycle 0, stalls high for 5 cycles, div_done on cycle 5, outputs idle on cycle 6.
- Two divides back-to-back -> second div_start exactly 1 cycle after first div_done.
- nrst=0 asserted in the 2nd RUN cycle -> next cycle all outputs 0, state HZ_IDLE, no div_done.
- HAZARD_PERF_CNT_EN, CNT_WIDTH=3, 10 stall cycles -> stall_cnt=7 (saturated). Without the macro -> stall_cnt=0.
